// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for dmem_access_ctrl.
//   c_*  : core MEM-stage request port (req/we/addr/wdata/size in; rdata/done/err out)
//   stall: pipeline stall, c_req & ~c_done
//   d_*  : debug/loader request port, same shape as c_*
//   m_*  : byte-wide data memory port (en/we/addr/wdata out; rdata in, one cycle after a read)
// Modports: slave = the controller, master = requesters plus memory.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              c_req;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [1:0]        c_size;
  logic [31:0]       c_rdata;
  logic              c_done;
  logic              c_err;
  logic              stall;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [1:0]        d_size;
  logic [31:0]       d_rdata;
  logic              d_done;
  logic              d_err;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic [7:0]        m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_size,
    output c_rdata, c_done, c_err, stall,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    output d_rdata, d_done, d_err,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_size,
    input  c_rdata, c_done, c_err, stall,
    output d_req, d_we, d_addr, d_wdata, d_size,
    input  d_rdata, d_done, d_err,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares a byte-wide data memory between the core MEM stage (c_*) and a
// debug/loader port (d_*). Each byte/half/word access is split into single-byte memory cycles,
// little-endian (byte at addr <-> data[7:0]); addresses wrap modulo 2^ADDR_W.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : dmem_access_ctrl_if.slave (core port, debug port, stall, memory port)
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses
// (done + err one cycle after grant, no memory cycle). Without it err is always 0 and
// unaligned accesses proceed bytewise.
module dmem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, RDRAIN, DONE} state_t;

  state_t            state;

  // accepted request (p0)
  logic              port_p0;  // 0 = core, 1 = debug
  logic              we_p0;
  logic              mis_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic [2:0]        n_p0;
  logic [2:0]        k_p0;

  // memory issue registers
  logic              m_en_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [7:0]        m_wdata_q;
  logic [1:0]        m_idx_q;

  // read return (p1): byte issued last cycle is on m_rdata this cycle
  logic              vld_p1;
  logic [1:0]        idx_p1;
  logic [31:0]       rbuf_p1;

  logic              c_done_q, d_done_q, c_err_q, d_err_q;
  logic [31:0]       c_rdata_q, d_rdata_q;

  // request mux: core wins whenever it is requesting
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              unused_addr_hi;

  always_comb begin
    req_we    = bus.d_we;
    req_addr  = bus.d_addr;
    req_wdata = bus.d_wdata;
    req_size  = bus.d_size;
    if (bus.c_req) begin
      req_we    = bus.c_we;
      req_addr  = bus.c_addr;
      req_wdata = bus.c_wdata;
      req_size  = bus.c_size;
    end
  end

  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction
`endif

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      port_p0   <= 1'b0;
      we_p0     <= 1'b0;
      mis_p0    <= 1'b0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      n_p0      <= '0;
      k_p0      <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_idx_q   <= '0;
      vld_p1    <= 1'b0;
      idx_p1    <= '0;
      rbuf_p1   <= '0;
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      c_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // p0 -> p1: remember which byte was read so it lands in the right lane next cycle
      vld_p1 <= m_en_q & ~m_we_q;
      idx_p1 <= m_idx_q;
      if (vld_p1) rbuf_p1[{idx_p1, 3'b000} +: 8] <= bus.m_rdata;

      case (state)
        IDLE: begin
          if (bus.c_req || bus.d_req) begin
            port_p0  <= ~bus.c_req;
            we_p0    <= req_we;
            addr_p0  <= req_addr[ADDR_W-1:0];
            wdata_p0 <= req_wdata;
            n_p0     <= size_to_n(req_size);
            k_p0     <= '0;
            rbuf_p1  <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            mis_p0   <= misaligned(req_size, req_addr[1:0]);
`else
            mis_p0   <= 1'b0;
`endif
            state    <= XFER;
          end
        end

        XFER: begin
          if (mis_p0) begin
            if (port_p0) begin
              d_done_q <= 1'b1;
              d_err_q  <= 1'b1;
            end else begin
              c_done_q <= 1'b1;
              c_err_q  <= 1'b1;
            end
            state <= DONE;
          end else if (k_p0 != n_p0) begin
            m_en_q   <= 1'b1;
            m_we_q   <= we_p0;
            m_addr_q <= addr_p0 + ADDR_W'(k_p0);
            m_idx_q  <= k_p0[1:0];
            if (we_p0) m_wdata_q <= wdata_p0[{k_p0[1:0], 3'b000} +: 8];
            k_p0     <= k_p0 + 3'd1;
          end else begin
            // one extra XFER cycle lets the last byte's memory cycle complete
            m_en_q <= 1'b0;
            m_we_q <= 1'b0;
            if (we_p0) begin
              if (port_p0) d_done_q <= 1'b1;
              else         c_done_q <= 1'b1;
              state <= DONE;
            end else begin
              state <= RDRAIN;
            end
          end
        end

        RDRAIN: begin
          // last read byte is on m_rdata now; publish the whole word with done
          if (port_p0) begin
            d_done_q  <= 1'b1;
            d_rdata_q <= merge_byte(rbuf_p1, idx_p1, bus.m_rdata);
          end else begin
            c_done_q  <= 1'b1;
            c_rdata_q <= merge_byte(rbuf_p1, idx_p1, bus.m_rdata);
          end
          state <= DONE;
        end

        DONE: begin
          c_done_q <= 1'b0;
          d_done_q <= 1'b0;
          c_err_q  <= 1'b0;
          d_err_q  <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.c_done  = c_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.c_err   = c_err_q;
  assign bus.d_err   = d_err_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.stall   = bus.c_req & ~c_done_q;

endmodule
